// File: rtl/proc_defs.sv
// Shared processor definitions: opcodes, sequencer state encodings and instruction fields.
package proc_defs;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_STORE = 4'd9;

  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_ULA_OP    = 4'd3,
    S_ULA_WAIT  = 4'd4,
    S_STORE_RES = 4'd5,
    S_MEM       = 4'd6,
    S_LOAD_WB   = 4'd7
  } state_e;

endpackage

// File: rtl/seq_ctrl_if.sv
// Handshake bundle between the sequencer (master) and the fetch/ULA/memory/regfile side (slave).
interface seq_ctrl_if;
  logic        instr_req;
  logic        instr_ack;
  logic [15:0] instr_data;
  logic        ula_start;
  logic [3:0]  ula_op;
  logic        ula_done;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic [3:0]  rf_raddr_a;
  logic [3:0]  rf_raddr_b;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic        rf_wsel;
  logic        pc_inc;
  logic        illegal_op;
  logic        timeout_err;
  logic [3:0]  state;

  modport master (
    output instr_req, ula_start, ula_op, mem_req, mem_we, rf_raddr_a, rf_raddr_b,
    output rf_we, rf_waddr, rf_wsel, pc_inc, illegal_op, timeout_err, state,
    input  instr_ack, instr_data, ula_done, mem_ack
  );

  modport slave (
    input  instr_req, ula_start, ula_op, mem_req, mem_we, rf_raddr_a, rf_raddr_b,
    input  rf_we, rf_waddr, rf_wsel, pc_inc, illegal_op, timeout_err, state,
    output instr_ack, instr_data, ula_done, mem_ack
  );
endinterface

// File: rtl/seq_ctrl_watchdog.sv
// Wait-state counter for one handshake phase; expired is high in the Limit-th waiting cycle.
module seq_watchdog #(
  parameter int unsigned Limit = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int unsigned Width = $clog2(Limit + 1);

  logic [Width-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == Width'(Limit - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer with handshaked fetch, ULA and memory phases.
// Define SEQ_TIMEOUT_EN to enable the per-phase wait-state watchdog.
module seq_ctrl
  import proc_defs::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic        clock,
  input logic        reset,
  seq_ctrl_if.master bus
);
  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  opc;
  logic        is_ula, is_mem, is_illegal;
  logic        tmo_fire;

  assign opc        = ir_q[OPC_MSB:OPC_LSB];
  assign is_ula     = (opc >= OP_ADD) && (opc <= OP_XOR);
  assign is_mem     = (opc == OP_LOAD) || (opc == OP_STORE);
  assign is_illegal = (opc > OP_STORE);

`ifdef SEQ_TIMEOUT_EN
  logic waiting, acked, wd_expired, wd_clear, timeout_q;

  always_comb begin
    waiting = 1'b0;
    acked   = 1'b0;
    case (state_q)
      S_FETCH:    begin waiting = 1'b1; acked = bus.instr_ack; end
      S_ULA_WAIT: begin waiting = 1'b1; acked = bus.ula_done;  end
      S_MEM:      begin waiting = 1'b1; acked = bus.mem_ack;   end
      default:    ;
    endcase
  end

  assign tmo_fire = waiting && !acked && wd_expired;
  // A timed-out fetch stays in S_FETCH, so the fire itself must also restart the count.
  assign wd_clear = (state_d != state_q) || tmo_fire;

  seq_watchdog #(
    .Limit(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .inc    (waiting),
    .expired(wd_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= tmo_fire;
  end

  assign bus.timeout_err = timeout_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign tmo_fire        = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.instr_ack) begin
          ir_d    = bus.instr_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_ula)      state_d = S_ULA_OP;
        else if (is_mem) state_d = S_MEM;
        else             state_d = S_FETCH;
      end
      S_ULA_OP: state_d = S_ULA_WAIT;
      S_ULA_WAIT: begin
        if (bus.ula_done)  state_d = S_STORE_RES;
        else if (tmo_fire) state_d = S_FETCH;
      end
      S_STORE_RES: state_d = S_FETCH;
      S_MEM: begin
        if (bus.mem_ack)   state_d = (opc == OP_LOAD) ? S_LOAD_WB : S_FETCH;
        else if (tmo_fire) state_d = S_FETCH;
      end
      S_LOAD_WB: state_d = S_FETCH;
      default:   state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RESET;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.ula_op     = opc;
  assign bus.rf_waddr   = ir_q[RD_MSB:RD_LSB];
  assign bus.rf_raddr_a = ir_q[RS1_MSB:RS1_LSB];
  assign bus.rf_raddr_b = ir_q[RS2_MSB:RS2_LSB];

  assign bus.instr_req  = (state_q == S_FETCH);
  assign bus.ula_start  = (state_q == S_ULA_OP);
  assign bus.mem_req    = (state_q == S_MEM);
  assign bus.mem_we     = (state_q == S_MEM) && (opc == OP_STORE);
  assign bus.rf_we      = (state_q == S_STORE_RES) || (state_q == S_LOAD_WB);
  assign bus.rf_wsel    = (state_q == S_LOAD_WB);
  assign bus.illegal_op = (state_q == S_DECODE) && is_illegal;

  // STORE retires in its ack cycle, so this one term must see mem_ack directly.
  assign bus.pc_inc = ((state_q == S_DECODE) && !is_ula && !is_mem) ||
                      (state_q == S_STORE_RES) || (state_q == S_LOAD_WB) ||
                      ((state_q == S_MEM) && (opc == OP_STORE) && bus.mem_ack && !reset);
endmodule

// File: tb/tb_seq_ctrl.sv
// Scoreboard bench for seq_ctrl: random instructions and ack delays against a phase-level model.
module tb_seq_ctrl;
  import proc_defs::*;

  localparam int unsigned TMO = 8;
`ifdef SEQ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  seq_ctrl_if bus ();

  seq_ctrl #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pc_inc;
    logic       rf_we;
    logic       rf_wsel;
    logic [3:0] waddr;
    logic       illegal;
    logic       tmo;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Retirement event an instruction must produce, straight from the opcode rules.
  function automatic ev_t retire_ev(input logic [15:0] ins);
    ev_t e;
    int  op;
    e        = '0;
    e.pc_inc = 1'b1;
    op       = int'(ins[15:12]);
    if (op >= 1 && op <= 8) begin
      e.rf_we   = 1'b1;
      e.rf_wsel = (op == 8);
      e.waddr   = ins[11:8];
    end else if (op >= 10) begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // Monitor: every cycle with a retirement-type output is matched against the queue head.
  always @(negedge clock) begin
    ev_t act, e;
    if (!reset && (bus.pc_inc || bus.rf_we || bus.illegal_op || bus.timeout_err)) begin
      act         = '0;
      act.pc_inc  = bus.pc_inc;
      act.rf_we   = bus.rf_we;
      act.rf_wsel = bus.rf_we ? bus.rf_wsel : 1'b0;
      act.waddr   = bus.rf_we ? bus.rf_waddr : 4'd0;
      act.illegal = bus.illegal_op;
      act.tmo     = bus.timeout_err;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: got %h expected none (t=%0t)", act, $time);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL event: got %h expected %h (t=%0t)", act, e, $time);
        end
      end
    end
  end

  task automatic wait_fetch(output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (bus.state != S_FETCH) begin
      step();
      if (++n > 200) begin
        chk("fetch_timeout", 32'(bus.state), 32'(S_FETCH));
        ok = 1'b0;
        return;
      end
    end
  endtask

  // fd: cycles before instr_ack; rd: wait cycles before ula_done/mem_ack.
  task automatic run_instr(input logic [15:0] ins, input int fd, input int rd);
    int  op, exp_lat, exp_mreq, cyc, mreq, ust, cnt, n;
    bit  is_ula, is_mem, to, ok;
    ev_t te;
    op      = int'(ins[15:12]);
    is_ula  = (op >= 1 && op <= 7);
    is_mem  = (op == 8 || op == 9);
    to      = TmoEn && (is_ula || is_mem) && (rd >= int'(TMO));
    exp_lat = fd + 2;
    if (is_ula)      exp_lat += to ? 1 + int'(TMO) : rd + 3;
    else if (is_mem) exp_lat += to ? int'(TMO) : rd + 1 + int'(op == 8);
    exp_mreq = is_mem ? (to ? int'(TMO) : rd + 1) : 0;
    te       = '0;
    te.tmo   = 1'b1;
    exp_q.push_back(to ? te : retire_ev(ins));

    wait_fetch(ok);
    if (!ok) return;
    chk("instr_req", 32'(bus.instr_req), 32'd1);
    cyc = 0;
    for (int i = 0; i < fd; i++) begin
      bus.instr_ack  = 1'b0;
      bus.instr_data = 16'($urandom);
      step();
      cyc++;
    end
    bus.instr_ack  = 1'b1;
    bus.instr_data = ins;
    step();
    cyc++;
    bus.instr_ack  = 1'b0;
    bus.instr_data = 16'($urandom);

    chk("decode_state", 32'(bus.state), 32'(S_DECODE));
    chk("ula_op", 32'(bus.ula_op), 32'(ins[15:12]));
    chk("raddr_a", 32'(bus.rf_raddr_a), 32'(ins[7:4]));
    chk("raddr_b", 32'(bus.rf_raddr_b), 32'(ins[3:0]));

    cnt  = -1;
    mreq = 0;
    ust  = 0;
    n    = 0;
    while (bus.state != S_FETCH) begin
      // Acks outside their own phase are junk that must be ignored.
      bus.instr_ack = 1'($urandom_range(0, 1));
      bus.mem_ack   = 1'($urandom_range(0, 1));
      bus.ula_done  = 1'($urandom_range(0, 1));
      case (bus.state)
        S_ULA_OP: ust++;
        S_ULA_WAIT: begin
          if (cnt < 0) cnt = rd;
          bus.ula_done = (cnt == 0);
          cnt--;
        end
        S_MEM: begin
          mreq++;
          chk("mem_we", 32'(bus.mem_we), 32'(op == 9));
          if (cnt < 0) cnt = rd;
          bus.mem_ack = (cnt == 0);
          cnt--;
        end
        default: ;
      endcase
      step();
      cyc++;
      if (++n > 300) begin
        chk("phase_timeout", 32'(bus.state), 32'(S_FETCH));
        break;
      end
    end
    bus.instr_ack = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.ula_done  = 1'b0;

    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("mem_req_cycles", 32'(mreq), 32'(exp_mreq));
    chk("ula_starts", 32'(ust), 32'(is_ula));
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({bus.instr_req, bus.ula_start, bus.ula_op, bus.mem_req, bus.mem_we,
                bus.rf_raddr_a, bus.rf_raddr_b, bus.rf_we, bus.rf_waddr, bus.rf_wsel,
                bus.pc_inc, bus.illegal_op, bus.timeout_err});
  endfunction

  initial begin
    bit ok;
    bus.instr_ack  = 1'b0;
    bus.instr_data = 16'h0000;
    bus.ula_done   = 1'b0;
    bus.mem_ack    = 1'b0;
    reset          = 1'b1;
    repeat (3) step();
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_outputs", all_outs(), 32'd0);
    reset = 1'b0;
    step();
    chk("post_reset_state", 32'(bus.state), 32'd1);
    chk("post_reset_req", 32'(bus.instr_req), 32'd1);

    run_instr(16'h1123, 0, 1);
    run_instr(16'h8A50, 0, 3);
    run_instr(16'h9034, 0, 0);
    run_instr(16'h0000, 0, 0);
    run_instr(16'hF000, 0, 0);

    repeat (40) begin
      run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 5));
    end

    if (TmoEn) begin
      run_instr(16'h9034, 0, 20);
      run_instr(16'h9034, 0, int'(TMO) - 1);
      run_instr(16'h8A50, 1, 30);
      run_instr(16'h3456, 0, 12);
      run_instr(16'h3456, 2, int'(TMO) - 1);
    end

    // Reset in the middle of a LOAD's memory phase abandons it silently.
    wait_fetch(ok);
    bus.instr_ack  = 1'b1;
    bus.instr_data = 16'h8A50;
    step();
    bus.instr_ack = 1'b0;
    step();
    chk("mid_mem_state", 32'(bus.state), 32'(S_MEM));
    reset = 1'b1;
    step();
    chk("mid_reset_state", 32'(bus.state), 32'd0);
    chk("mid_reset_outputs", all_outs(), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("mid_release_state", 32'(bus.state), 32'd1);
    chk("mid_release_req", 32'(bus.instr_req), 32'd1);

    run_instr(16'h2567, 1, 2);
    repeat (5) step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
